vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BP, default 33, vertical back porch in lines.
REQ-009 Parameter HS_POL, default 0, hsync active level (0 = active-low).
REQ-010 Parameter VS_POL, default 0, vsync active level (0 = active-low).
REQ-011 clk  input  1  system clock.
REQ-012 rst_n  input  1  reset, asynchronous, active-low.
REQ-013 pix_en  input  1  pixel clock enable; position advances only on clk edges with pix_en=1.
REQ-014 restart  input  1  synchronous frame restart.
REQ-015 hsync  output  1  horizontal sync to the display.
REQ-016 vsync  output  1  vertical sync to the display.
REQ-017 de  output  1  data enable; 1 while the position is in the visible area.
REQ-018 x  output  10  current horizontal count; feeds the downstream pixel/colour stage.
REQ-019 y  output  10  current vertical count; feeds the downstream pixel/colour stage.
REQ-020 sol  output  1  start-of-line pulse.
REQ-021 sof  output  1  start-of-frame pulse.

Function
REQ-022 The block SHALL hold 10-bit counters h_cnt and v_cnt, with H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-023 Elaboration SHALL fail if H_TOTAL > 1024 or V_TOTAL > 1024.
REQ-024 On a clk edge with pix_en=1 and restart=0, the counters SHALL advance as follows.
- h_cnt increments by 1.
- At h_cnt = H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
- At h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1, both counters wrap to 0.
REQ-025 On an edge with pix_en=0 and restart=0, the counters SHALL hold.
REQ-026 On an edge with restart=1, the counters SHALL load h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1, regardless of pix_en; restart has priority.
REQ-027 Each counter SHALL track a phase state, ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
- Horizontal phase transitions occur at h_cnt boundaries.
- Vertical phase transitions occur only at the h_cnt wrap.
REQ-028 All outputs SHALL be registered and SHALL reflect the counter values held in the same cycle, with zero latency relative to the counters.
REQ-029 Outputs SHALL be decoded from the counters as follows.
- x = h_cnt and y = v_cnt at all times.
- de = 1 iff h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-030 hsync SHALL equal HS_POL iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751), and SHALL equal ~HS_POL otherwise.
REQ-031 vsync SHALL equal VS_POL iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), and SHALL equal ~VS_POL otherwise; vsync changes only together with the h_cnt wrap.
REQ-032 sol SHALL be 1 for exactly one clk cycle following an advancing edge that sets h_cnt to 0; this applies to every line, blanked lines included.
REQ-033 sof SHALL be 1 for exactly one clk cycle following an advancing edge that sets both counters to 0.
REQ-034 sol and sof SHALL be 0 in all other cycles, including cycles where pix_en=0 holds the counters at 0 and cycles following a restart load.

Reset
REQ-035 While rst_n=0, the block SHALL asynchronously force the following values.
- h_cnt = H_TOTAL-1 (799), v_cnt = V_TOTAL-1 (524).
- x = 799, y = 524, de = 0.
- hsync = ~HS_POL, vsync = ~VS_POL.
- sol = 0, sof = 0.
REQ-036 After rst_n deasserts, the first edge with pix_en=1 SHALL produce the following values in the next cycle: x=0, y=0, de=1, sol=1, sof=1.

Verification
REQ-037 Release reset with pix_en=1 held constant -> the cycle after the first edge shows x=0, y=0, de=1, sof=1, sol=1; the following cycle shows sof=0, sol=0, x=1.
REQ-038 Run pix_en=1 over one line -> de=0 for x=640..799; hsync=0 for exactly 96 cycles, starting at x=656; sol period is 800 cycles.
REQ-039 Run pix_en=1 over a full frame -> vsync=0 for y=490..491 (1600 cycles); sof period is 420000 cycles; de never asserts for y >= 480.
REQ-040 Drive pix_en with a 1-of-2 pattern -> the counters advance once per 2 clk cycles; sof and sol each remain 1 clk wide; the frame period is 840000 clk cycles.
REQ-041 Assert restart at x=300, y=100 with pix_en=1 -> the next cycle shows x=799, y=524, de=0, sof=0; the following enabled edge gives x=0, y=0, sof=1.
REQ-042 Assert rst_n=0 mid-frame at x=700, y=491 -> the outputs take the REQ-035 values immediately, without waiting for a clk edge; hsync=1, vsync=1.

Source files
------------

// File: rtl/vga_timing.sv
// VGA raster timing generator: free-running h/v position counters with
// phase tracking, registered sync/data-enable decode and line/frame pulses.
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    input  logic       restart,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       sol,
    output logic       sof
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024) begin : g_bad_h_total
        $fatal(1, "vga_timing: H_TOTAL exceeds 10-bit counter range");
    end
    if (V_TOTAL > 1024) begin : g_bad_v_total
        $fatal(1, "vga_timing: V_TOTAL exceeds 10-bit counter range");
    end
    // Every phase must be non-empty so the phase walk never skips a state.
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_phase
        $fatal(1, "vga_timing: every timing interval must be at least 1");
    end

    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FP_START  = 10'(H_ACTIVE);
    localparam logic [9:0] H_SY_START  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_BP_START  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FP_START  = 10'(V_ACTIVE);
    localparam logic [9:0] V_SY_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_BP_START  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic       HS_ON       = (HS_POL != 0);
    localparam logic       VS_ON       = (VS_POL != 0);

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    logic [9:0] h_cnt, v_cnt, h_nxt, v_nxt;
    phase_t     h_ph, v_ph, h_ph_nxt, v_ph_nxt;
    logic       adv, h_wrap;
    logic       hsync_d, vsync_d, de_d, sol_d, sof_d;

    // Counter next-values; restart overrides the pixel enable.
    always_comb begin
        adv    = pix_en && !restart;
        h_wrap = adv && (h_cnt == H_LAST);
        h_nxt  = h_cnt;
        v_nxt  = v_cnt;
        if (restart) begin
            h_nxt = H_LAST;
            v_nxt = V_LAST;
        end else if (adv) begin
            if (h_wrap) begin
                h_nxt = '0;
                v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
                h_nxt = h_cnt + 10'd1;
            end
        end
    end

    // Phase next-state: entering a phase is detected on the counter's next value.
    always_comb begin
        h_ph_nxt = h_ph;
        v_ph_nxt = v_ph;
        if (restart) begin
            h_ph_nxt = PH_BACK;
            v_ph_nxt = PH_BACK;
        end else begin
            case (h_ph)
                PH_ACTIVE: if (h_nxt == H_FP_START) h_ph_nxt = PH_FRONT;
                PH_FRONT:  if (h_nxt == H_SY_START) h_ph_nxt = PH_SYNC;
                PH_SYNC:   if (h_nxt == H_BP_START) h_ph_nxt = PH_BACK;
                PH_BACK:   if (h_nxt == 10'd0)      h_ph_nxt = PH_ACTIVE;
                default:   h_ph_nxt = PH_BACK;
            endcase
            if (h_wrap) begin
                case (v_ph)
                    PH_ACTIVE: if (v_nxt == V_FP_START) v_ph_nxt = PH_FRONT;
                    PH_FRONT:  if (v_nxt == V_SY_START) v_ph_nxt = PH_SYNC;
                    PH_SYNC:   if (v_nxt == V_BP_START) v_ph_nxt = PH_BACK;
                    PH_BACK:   if (v_nxt == 10'd0)      v_ph_nxt = PH_ACTIVE;
                    default:   v_ph_nxt = PH_BACK;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= H_LAST;
            v_cnt <= V_LAST;
            h_ph  <= PH_BACK;
            v_ph  <= PH_BACK;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            h_ph  <= h_ph_nxt;
            v_ph  <= v_ph_nxt;
        end
    end

    // Decode from next-state so registered outputs line up with the counters.
    always_comb begin
        hsync_d = (h_ph_nxt == PH_SYNC) ? HS_ON : ~HS_ON;
        vsync_d = (v_ph_nxt == PH_SYNC) ? VS_ON : ~VS_ON;
        de_d    = (h_ph_nxt == PH_ACTIVE) && (v_ph_nxt == PH_ACTIVE);
        sol_d   = h_wrap;
        sof_d   = h_wrap && (v_cnt == V_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync <= ~HS_ON;
            vsync <= ~VS_ON;
            de    <= 1'b0;
            sol   <= 1'b0;
            sof   <= 1'b0;
        end else begin
            hsync <= hsync_d;
            vsync <= vsync_d;
            de    <= de_d;
            sol   <= sol_d;
            sof   <= sof_d;
        end
    end

    assign x = h_cnt;
    assign y = v_cnt;

endmodule

// File: tb/tb_vga_timing.sv
// Randomised bench for vga_timing on a reduced raster, checked against a
// linear frame-position model (pixel index modulo frame size).
module tb_vga_timing;

    localparam int HA = 16, HF = 4, HS = 6, HB = 5;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int TOT = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_en = 1'b0;
    logic       restart = 1'b0;
    logic       hsync, vsync, de, sol, sof;
    logic [9:0] x, y;

    vga_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(0), .VS_POL(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .restart(restart),
        .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
        .sol(sol), .sof(sof)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail = 0;
    int   pos;
    logic esol, esof;
    int   cyc = 0;
    bit   meas = 0;
    int   exp_sof_per, exp_sol_per, last_sof, last_sol;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected outputs follow directly from the frame position.
    task automatic check_all();
        int h, v;
        h = pos % HT;
        v = pos / HT;
        chk("x", 32'(x), h);
        chk("y", 32'(y), v);
        chk("de", 32'(de), (h < HA && v < VA) ? 1 : 0);
        chk("hsync", 32'(hsync), (h >= HA + HF && h < HA + HF + HS) ? 0 : 1);
        chk("vsync", 32'(vsync), (v >= VA + VF && v < VA + VF + VS) ? 0 : 1);
        chk("sol", 32'(sol), 32'(esol));
        chk("sof", 32'(sof), 32'(esof));
    endtask

    task automatic step(input logic pe, input logic rs);
        pix_en  = pe;
        restart = rs;
        @(posedge clk);
        cyc++;
        if (rs) begin
            pos = TOT - 1; esol = 0; esof = 0;
        end else if (pe) begin
            pos  = (pos + 1) % TOT;
            esol = (pos % HT) == 0;
            esof = (pos == 0);
        end else begin
            esol = 0; esof = 0;
        end
        #1;
        check_all();
        if (sof === 1'b1) begin
            if (meas && last_sof >= 0) chk("sof_period", cyc - last_sof, exp_sof_per);
            last_sof = cyc;
        end
        if (sol === 1'b1) begin
            if (meas && last_sol >= 0) chk("sol_period", cyc - last_sol, exp_sol_per);
            last_sol = cyc;
        end
    endtask

    task automatic run_to(input int tx, input int ty, input string tag);
        int k;
        k = 0;
        while (!(pos % HT == tx && pos / HT == ty) && k < TOT + 2) begin
            step(1'b1, 1'b0);
            k++;
        end
        chk({tag, "_x"}, 32'(x), tx);
        chk({tag, "_y"}, 32'(y), ty);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_low, vs_low, de_hi;
        pos = TOT - 1; esol = 0; esof = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Constant enable: line and frame periods plus per-frame pulse counts.
        meas = 1; exp_sof_per = TOT; exp_sol_per = HT; last_sof = -1; last_sol = -1;
        for (int i = 0; i < 2 * TOT + 5; i++) step(1'b1, 1'b0);
        hs_low = 0; vs_low = 0; de_hi = 0;
        for (int i = 0; i < TOT; i++) begin
            step(1'b1, 1'b0);
            if (hsync === 1'b0) hs_low++;
            if (vsync === 1'b0) vs_low++;
            if (de === 1'b1) de_hi++;
        end
        chk("hsync_low_per_frame", hs_low, HS * VT);
        chk("vsync_low_per_frame", vs_low, VS * HT);
        chk("de_high_per_frame", de_hi, HA * VA);

        // Enable every other clock doubles both periods.
        exp_sof_per = 2 * TOT; exp_sol_per = 2 * HT; last_sof = -1; last_sol = -1;
        for (int i = 0; i < 4 * TOT + 10; i++) step((i % 2) == 0, 1'b0);
        meas = 0;

        // Directed restart mid-frame, then restart while the enable is low.
        run_to(5, 3, "restart_pt");
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        chk("restart_sof", 32'(sof), 1);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);

        // Random enable with occasional restarts.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);

        // Asynchronous reset inside both sync regions.
        run_to(HA + HF + 1, VA + VF + 1, "sync_pt");
        chk("pre_rst_hsync", 32'(hsync), 0);
        chk("pre_rst_vsync", 32'(vsync), 0);
        #2;
        rst_n = 1'b0;
        #1;
        pos = TOT - 1; esol = 0; esof = 0;
        check_all();
        chk("async_rst_hsync", 32'(hsync), 1);
        chk("async_rst_vsync", 32'(vsync), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        step(1'b1, 1'b0);
        chk("post_rst_sof", 32'(sof), 1);
        step(1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
